// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and helpers.
//   - 640x480@60 defaults used by vga_timing_gen
//   - axis_total / sync_start / sync_end helpers for one raster axis
//   - alternative mode constant sets (800x600@60, 320x240)
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISP  = 640;
  localparam int unsigned VGA_H_FRONT = 16;
  localparam int unsigned VGA_H_SYNC  = 96;
  localparam int unsigned VGA_H_BACK  = 48;
  localparam int unsigned VGA_V_DISP  = 480;
  localparam int unsigned VGA_V_FRONT = 10;
  localparam int unsigned VGA_V_SYNC  = 2;
  localparam int unsigned VGA_V_BACK  = 33;

  typedef struct packed {
    logic [11:0] disp;
    logic [11:0] front;
    logic [11:0] sync;
    logic [11:0] back;
  } axis_timing_t;

  // 800x600@60 (40 MHz pixel clock), positive syncs on most monitors
  localparam axis_timing_t MODE_800X600_H = '{disp: 12'd800, front: 12'd40, sync: 12'd128, back: 12'd88};
  localparam axis_timing_t MODE_800X600_V = '{disp: 12'd600, front: 12'd1,  sync: 12'd4,   back: 12'd23};

  // 320x240 low-resolution raster
  localparam axis_timing_t MODE_320X240_H = '{disp: 12'd320, front: 12'd8,  sync: 12'd32,  back: 12'd40};
  localparam axis_timing_t MODE_320X240_V = '{disp: 12'd240, front: 12'd3,  sync: 12'd3,   back: 12'd16};

  function automatic int unsigned axis_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  // First count at which the sync pulse is active.
  function automatic int unsigned sync_start(input int unsigned disp, input int unsigned front);
    return disp + front;
  endfunction

  // First count after the sync pulse (exclusive end).
  function automatic int unsigned sync_end(input int unsigned disp, input int unsigned front,
                                           input int unsigned sync);
    return disp + front + sync;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis counter (horizontal or vertical).
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance the count by one this clock
//   count      : current position 0..TOTAL-1
//   wrap       : inc is high and count is at TOTAL-1 (next value is 0)
//   active     : count lies in the display region
//   sync       : count lies in the sync pulse window
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISP  = VGA_H_DISP,
  parameter int unsigned FRONT = VGA_H_FRONT,
  parameter int unsigned SYNC  = VGA_H_SYNC,
  parameter int unsigned BACK  = VGA_H_BACK,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int unsigned TOTAL = axis_total(DISP, FRONT, SYNC, BACK);

  // BACK >= 1 keeps every bound below TOTAL, so all fit in CW bits.
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DISP_C  = CW'(DISP);
  localparam logic [CW-1:0] SYNC_LO = CW'(sync_start(DISP, FRONT));
  localparam logic [CW-1:0] SYNC_HI = CW'(sync_end(DISP, FRONT, SYNC));

  assign wrap   = inc && (count == LAST);
  assign active = (count < DISP_C);
  assign sync   = (count >= SYNC_LO) && (count < SYNC_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator and pixel aligner.
//   clk_25, rst     : pixel clock, asynchronous active-low reset
//   en              : count enable; low freezes counters, request stage and delay line
//   r, g, b         : pixel colour, valid PIX_LATENCY clocks after its x/y request
//   x, y            : requested pixel coordinate (0 outside the visible area)
//   req_active      : x/y lies inside the visible area
//   frame_start     : one-clock strobe with the request for pixel (0,0)
//   line_start      : one-clock strobe with the request for column 0 of a visible line
//   vga_r/g/b       : colour gated by vga_blank_n
//   vga_blank_n     : high during visible pixels, aligned with r/g/b
//   vga_hs, vga_vs  : syncs with selectable active level, aligned with r/g/b
//   vga_sync_n      : tied low
//   vga_clk         : copy of clk_25
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISP      = VGA_H_DISP,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_DISP      = VGA_V_DISP,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned PIX_LATENCY = 2,
  parameter int unsigned CW          = 10
) (
  input  logic          clk_25,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          req_active,
  output logic          frame_start,
  output logic          line_start,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_blank_n,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_sync_n,
  output logic          vga_clk
);

  localparam int unsigned     H_TOTAL = axis_total(H_DISP, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned     V_TOTAL = axis_total(V_DISP, V_FRONT, V_SYNC, V_BACK);
  localparam longint unsigned SPAN    = 64'd1 << CW;

  if (H_DISP == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_DISP == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_err_timing
    $error("vga_timing_gen: every timing parameter must be at least 1");
  end
  if (64'(H_TOTAL) > SPAN || 64'(V_TOTAL) > SPAN) begin : g_err_width
    $error("vga_timing_gen: CW too narrow for the raster totals");
  end
  if (PIX_LATENCY > 15) begin : g_err_latency
    $error("vga_timing_gen: PIX_LATENCY must be 0..15");
  end

  logic [CW-1:0] hc, vc;
  logic          h_wrap, h_active, h_sync;
  logic          v_wrap, v_active, v_sync;
  logic          vis;

  vga_axis_counter #(
    .DISP(H_DISP), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)
  ) u_h (
    .clk(clk_25), .rst_n(rst), .inc(en),
    .count(hc), .wrap(h_wrap), .active(h_active), .sync(h_sync)
  );

  // The line counter steps on the pixel counter wrap, so vsync can only
  // change at the start of a line.
  vga_axis_counter #(
    .DISP(V_DISP), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)
  ) u_v (
    .clk(clk_25), .rst_n(rst), .inc(h_wrap),
    .count(vc), .wrap(v_wrap), .active(v_active), .sync(v_sync)
  );

  assign vis = h_active && v_active;

  // Request stage. origin_q tracks "counters are at (0,0)" from the two wrap
  // flags instead of comparing both counters against zero.
  logic origin_q;
  logic hs0, vs0;

  always_ff @(posedge clk_25 or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      req_active  <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs0         <= 1'b0;
      vs0         <= 1'b0;
      origin_q    <= 1'b1;
    end else if (en) begin
      x           <= vis ? hc : '0;
      y           <= vis ? vc : '0;
      req_active  <= vis;
      frame_start <= origin_q;
      line_start  <= (hc == '0) && v_active;
      hs0         <= h_sync;
      vs0         <= v_sync;
      origin_q    <= h_wrap && v_wrap;
    end else begin
      // Strobes drop while frozen so a held request is not seen twice.
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

  // {blank_n, hs, vs} as seen at the DAC, PIX_LATENCY enabled clocks behind
  // the request stage.
  logic [2:0] tap;

  if (PIX_LATENCY == 0) begin : g_bypass
    assign tap = {req_active, hs0, vs0};
  end else begin : g_delay
    logic [2:0] dl [PIX_LATENCY];

    always_ff @(posedge clk_25 or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < PIX_LATENCY; i++) dl[i] <= 3'b000;
      end else if (en) begin
        dl[0] <= {req_active, hs0, vs0};
        for (int i = 1; i < PIX_LATENCY; i++) dl[i] <= dl[i-1];
      end
    end

    assign tap = dl[PIX_LATENCY-1];
  end

  assign vga_blank_n = tap[2];
  assign vga_hs      = HS_POL ? tap[1] : ~tap[1];
  assign vga_vs      = VS_POL ? tap[0] : ~tap[0];

  assign vga_r      = vga_blank_n ? r : 8'h00;
  assign vga_g      = vga_blank_n ? g : 8'h00;
  assign vga_b      = vga_blank_n ? b : 8'h00;
  assign vga_sync_n = 1'b0;
  assign vga_clk    = clk_25;

endmodule
